seq_magnitude_comparator: RTL

Parametrised, multi-cycle magnitude comparator for two WIDTH-bit operands. Evaluates CHUNK bits per clock, MSB chunk first, with optional early exit on the first differing chunk and a per-operation signed/unsigned mode. Registered one-hot gt/eq/lt results plus a start/busy/done handshake. Used where wide comparisons must not sit in a single combinational path, or where comparator area must be traded for latency.

---
 rtl/seq_magnitude_comparator_pkg.sv | 30 +++
 rtl/seq_magnitude_comparator_if.sv | 26 ++
 rtl/seq_magnitude_comparator_chunk_compare.sv | 20 ++
 rtl/seq_magnitude_comparator.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/seq_magnitude_comparator_pkg.sv
// cmp_pkg: shared types and helpers for the sequential magnitude comparator.
//   state_t      - controller states (IDLE, RUN, DONE)
//   res_t        - result vector {gt, eq, lt}, always one-hot when valid
//   RES_GT/EQ/LT - result encodings
//   nchunk()     - number of CHUNK-bit slices in a WIDTH-bit operand
//   idx_width()  - chunk index counter width (never below 1 bit)
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [2:0] res_t;

    localparam res_t RES_NONE = 3'b000;
    localparam res_t RES_GT   = 3'b100;
    localparam res_t RES_EQ   = 3'b010;
    localparam res_t RES_LT   = 3'b001;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_magnitude_comparator_if.sv
// Request/result bundle for seq_magnitude_comparator.
//   master: drives start, signed_mode, a, b; observes busy, done, gt, eq, lt
//   slave : the comparator side of the same signals
interface seq_magnitude_comparator_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             gt;
    logic             eq;
    logic             lt;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, gt, eq, lt
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, gt, eq, lt
    );
endinterface

// File: rtl/seq_magnitude_comparator_chunk_compare.sv
// chunk_compare: purely combinational unsigned compare of one CHUNK-bit slice.
//   a, b : CHUNK-bit unsigned slices
//   gt   : a > b
//   eq   : a == b
//   lt   : a < b
module chunk_compare #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             gt,
    output logic             eq,
    output logic             lt
);
    always_comb begin
        gt = (a > b);
        eq = (a == b);
        lt = (a < b);
    end
endmodule

// File: rtl/seq_magnitude_comparator.sv
// seq_magnitude_comparator: multi-cycle WIDTH-bit magnitude comparator that
// walks CHUNK bits per clock from the most significant slice downwards.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : slave side of seq_magnitude_comparator_if
//           start/signed_mode/a/b in (latched on acceptance),
//           busy/done/gt/eq/lt out (all derived from registers)
// EARLY_EXIT=1 finishes on the first differing slice; EARLY_EXIT=0 always
// scans every slice so latency is constant.
module seq_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int CHUNK      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    seq_magnitude_comparator_if.slave bus
);
    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IDX_W  = idx_width(NCHUNK);
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(NCHUNK - 1);
    localparam logic [CHUNK-1:0] MSB_MASK = CHUNK'(1) << (CHUNK - 1);

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             signed_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             decided_reg;
    res_t             pend_reg;   // first decision, kept hidden until done
    res_t             res_reg;    // visible {gt, eq, lt}

    logic [CHUNK-1:0] a_chunk [NCHUNK];
    logic [CHUNK-1:0] b_chunk [NCHUNK];
    logic [CHUNK-1:0] cur_a;
    logic [CHUNK-1:0] cur_b;
    logic             chunk_gt;
    logic             chunk_eq;
    logic             chunk_lt;
    logic             accept;
    logic             finish;
    logic             busy_int;
    logic             done_int;

    // Slice the latched operands. Flipping the sign bit of the top slice maps
    // two's-complement ordering onto unsigned ordering.
    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
        if (gi == NCHUNK - 1) begin : g_top
            assign a_chunk[gi] = a_reg[gi*CHUNK +: CHUNK] ^ (signed_reg ? MSB_MASK : '0);
            assign b_chunk[gi] = b_reg[gi*CHUNK +: CHUNK] ^ (signed_reg ? MSB_MASK : '0);
        end else begin : g_low
            assign a_chunk[gi] = a_reg[gi*CHUNK +: CHUNK];
            assign b_chunk[gi] = b_reg[gi*CHUNK +: CHUNK];
        end
    end

    assign cur_a = a_chunk[idx_reg];
    assign cur_b = b_chunk[idx_reg];

    chunk_compare #(
        .CHUNK (CHUNK)
    ) u_chunk_compare (
        .a  (cur_a),
        .b  (cur_b),
        .gt (chunk_gt),
        .eq (chunk_eq),
        .lt (chunk_lt)
    );

    assign accept = bus.start && (state_reg != RUN);
    assign finish = (state_reg == RUN) && (state_next == DONE);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (((EARLY_EXIT != 0) && !chunk_eq) || (idx_reg == '0)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = bus.start ? RUN : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode: a function of the state register only
    always_comb begin
        busy_int = (state_reg == RUN);
        done_int = (state_reg == DONE);
    end

    // Operand latch, slice walk and result capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg       <= '0;
            b_reg       <= '0;
            signed_reg  <= 1'b0;
            idx_reg     <= '0;
            decided_reg <= 1'b0;
            pend_reg    <= RES_NONE;
            res_reg     <= RES_NONE;
        end else if (accept) begin
            a_reg       <= bus.a;
            b_reg       <= bus.b;
            signed_reg  <= bus.signed_mode;
            idx_reg     <= IDX_TOP;
            decided_reg <= 1'b0;
            pend_reg    <= RES_NONE;
            res_reg     <= RES_NONE;
        end else if (state_reg == RUN) begin
            // Only the first differing slice counts; lower ones are ignored.
            if (!decided_reg && !chunk_eq) begin
                decided_reg <= 1'b1;
                pend_reg    <= chunk_gt ? RES_GT : RES_LT;
            end
            if (idx_reg != '0) begin
                idx_reg <= idx_reg - 1'b1;
            end
            if (finish) begin
                if (decided_reg) begin
                    res_reg <= pend_reg;
                end else if (chunk_gt) begin
                    res_reg <= RES_GT;
                end else if (chunk_lt) begin
                    res_reg <= RES_LT;
                end else begin
                    res_reg <= RES_EQ;
                end
            end
        end
    end

    assign bus.busy = busy_int;
    assign bus.done = done_int;
    assign bus.gt   = res_reg[2];
    assign bus.eq   = res_reg[1];
    assign bus.lt   = res_reg[0];

endmodule
